status_reg_unit: RTL
====================

Name: status_reg_unit

Overview:
- Holds the architectural NZCV status register of the pipelined core and supplies the 4-bit Status vector to the condition-check stage in ID.
- Tracks whether the instruction now in EX will set flags (S bit). Commits ALU flags at the end of EX.
- Either forwards in-flight flags or raises a one-cycle flag hazard stall for conditional instructions in ID.
- Sits between the EX-stage ALU (producer) and the ID-stage condition checker (consumer).

Parameters:
- BYPASS, 1, 1 = forward EX ALU flags to ID; 0 = stall ID on a flag dependency.
- CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  external hazard stall; ID is held and a bubble enters EX.
- flush  input  1  taken branch in EX; the ID instruction is killed and a bubble enters EX.
- id_valid  input  1  ID holds a real instruction.
- id_cond  input  4  condition field of the ID instruction; 4'b1110 = always.
- id_s  input  1  ID instruction sets flags.
- alu_flags  input  4  EX ALU flags, same bit order as status.
- status  output  4  registered NZCV: bit3 N, bit2 Z, bit1 C, bit0 V.
- status_fwd  output  4  Status vector for the condition checker (bypassed or registered).
- ex_sets_flags  output  1  EX slot is valid and has S=1.
- flag_hazard  output  1  stall request to the hazard unit; combinational.
- stall_cnt  output  CNT_W  count of cycles with flag_hazard=1; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clock edge): status=4'b0000, EX slot empty (ex_valid=0, ex_s=0), stall_cnt=0.
  - After reset: ex_sets_flags=0, flag_hazard=0, status_fwd=4'b0000.
  - rst has priority over every other input, including mid-stall and mid-flush.
- EX slot state: ex_valid, ex_s. Each edge:
  - If flush, freeze or flag_hazard is asserted, the slot loads a bubble (ex_valid=0, ex_s=0).
  - Otherwise it loads id_valid and id_valid&id_s.
- Commit: at each edge with ex_valid&ex_s=1, status <= alu_flags.
  - The commit happens even when flush or freeze is asserted in the same cycle. flush kills only the younger ID instruction.
- ex_sets_flags = ex_valid & ex_s (combinational from slot state).
- status_fwd:
  - BYPASS=1: alu_flags when ex_sets_flags=1, else status.
  - BYPASS=0: always status.
- flag_hazard:
  - BYPASS=1: always 0.
  - BYPASS=0: 1 when id_valid & (id_cond != 4'b1110) & ex_sets_flags & ~flush.
  - A hazard lasts exactly one cycle. The stall inserts a bubble, so the next cycle has ex_sets_flags=0 and status already holds the committed flags.
- Unconditional ID instructions (cond 4'b1110) never stall, even when they have S=1.
- Back-to-back S instructions: each commits in order. The later one's flags win and never merge with earlier flags.
- stall_cnt increments by 1 on each edge with flag_hazard=1 and holds at 2^CNT_W-1.
- freeze and flag_hazard together: one bubble. stall_cnt still increments.
- Latency:
  - flags from an S instruction are visible on status 1 cycle after it occupies EX.
  - With BYPASS=1 they are visible on status_fwd in the same cycle.

Decomposition:
- Shared package (core_pkg):
  - status bit index constants: N=3, Z=2, C=1, V=0.
  - COND_AL=4'b1110.
  - a 4-bit status typedef shared with the condition checker.
- One natural sub-module: ex_flag_slot, the EX-slot register with bubble-insert logic.
- Hazard logic, bypass mux and counter stay in the top level.

Test Plan:
- Reset: drive rst=1 for 2 cycles with alu_flags=4'b1111 and id_s=1 -> status=0, status_fwd=0, ex_sets_flags=0, stall_cnt=0.
- Commit: S instruction in ID (cond 1110), next cycle alu_flags=4'b0100 -> ex_sets_flags=1, status=4'b0100 one edge later. A non-S instruction that follows leaves status unchanged.
- Bypass (BYPASS=1): S instruction in EX with alu_flags=4'b1000, conditional instruction in ID (cond 0100) -> status_fwd=4'b1000 in the same cycle, flag_hazard=0.
- Stall (BYPASS=0): same stimulus -> flag_hazard=1 for exactly one cycle, bubble enters EX, status=4'b1000 on the next cycle, stall_cnt=1.
- Flush: S instruction in EX (alu_flags=4'b0010) with flush=1, S instruction in ID -> status=4'b0010 after the edge, ID S instruction not captured, ex_sets_flags=0 next cycle, no hazard.
- Saturation and reset: CNT_W=2, force 5 hazard cycles -> stall_cnt=3. Then assert rst during a hazard -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: NZCV bit positions, the always-condition code and
// the status vector type used by the flag unit and the condition checker.
package core_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef logic [3:0] status_t;

  // Anything other than "always" reads the flags in ID and can depend on EX.
  function automatic logic is_conditional(input logic [3:0] cond);
    return cond != COND_AL;
  endfunction

endpackage

// File: rtl/ex_flag_slot.sv
// EX-stage slot tracking whether the instruction in EX is real and sets flags.
// A bubble is loaded whenever ID does not advance into EX this cycle.
module ex_flag_slot (
  input  logic clk,
  input  logic rst,
  input  logic bubble,
  input  logic id_valid,
  input  logic id_s,
  output logic ex_valid,
  output logic ex_s
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_s     <= 1'b0;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_s     <= 1'b0;
    end else begin
      ex_valid <= id_valid;
      ex_s     <= id_valid & id_s;
    end
  end

endmodule

// File: rtl/status_reg_unit.sv
// Architectural NZCV register with EX commit, ID-side bypass or one-cycle
// flag hazard stall, and a saturating count of hazard stall cycles.
module status_reg_unit
  import core_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_s,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       status,
  output logic [3:0]       status_fwd,
  output logic             ex_sets_flags,
  output logic             flag_hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  logic    ex_valid;
  logic    ex_s;
  logic    slot_bubble;
  status_t status_q;

  assign slot_bubble = freeze | flush | flag_hazard;

  ex_flag_slot u_slot (
    .clk      (clk),
    .rst      (rst),
    .bubble   (slot_bubble),
    .id_valid (id_valid),
    .id_s     (id_s),
    .ex_valid (ex_valid),
    .ex_s     (ex_s)
  );

  assign ex_sets_flags = ex_valid & ex_s;

  // The EX instruction is older than anything flush or freeze acts on, so it
  // always commits its flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else if (ex_sets_flags) begin
      status_q <= alu_flags;
    end
  end

  assign status = status_q;

  always_comb begin
    status_fwd  = status_q;
    flag_hazard = 1'b0;
    if (BYPASS) begin
      if (ex_sets_flags) begin
        status_fwd = alu_flags;
      end
    end else begin
      flag_hazard = id_valid & is_conditional(id_cond) & ex_sets_flags & ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (flag_hazard && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
